// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver -- asynchronous serial (UART-style) byte receiver, 8N1 framing.
//
// Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
// Each bit lasts SIGNAL_DURATION+1 clock cycles. The line is sampled near
// the middle of every bit after a 2-flop synchronizer.
//
// Parameters
//   SIGNAL_DURATION  clock cycles per bit minus one (minimum 1)
//
// Ports
//   clk_i equivalent: clk          single clock, rising edge
//   rst                            synchronous active-high reset
//   RxD                            asynchronous serial input, idle high
//   RxD_data    [7:0]              last correctly framed byte
//   data_ready                     one-cycle pulse when RxD_data updates
//   frame_error                    one-cycle pulse on a bad (low) stop bit
//   rx_busy                        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module receiver #(
   parameter int unsigned SIGNAL_DURATION = 433
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       data_ready,
   output logic       frame_error,
   output logic       rx_busy
);

   localparam int unsigned CW   = (SIGNAL_DURATION < 1) ? 1 : $clog2(SIGNAL_DURATION + 1);
   localparam int unsigned HALF = SIGNAL_DURATION / 2;

   localparam logic [CW-1:0] HALF_C = CW'(HALF);
   localparam logic [CW-1:0] FULL_C = CW'(SIGNAL_DURATION);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        dr_q, dr_d;
   logic        fe_q, fe_d;
   logic        sync1_q, sync2_q;
   logic        rx;

   // Two-flop synchronizer; both stages reset to the idle (high) level so
   // reset release never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= RxD;
         sync2_q <= sync1_q;
      end
   end

   assign rx = sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         dr_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         dr_q    <= dr_d;
         fe_q    <= fe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      dr_d    = 1'b0;
      fe_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!rx) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end

         // Wait half a bit, then confirm the start bit is still low; a high
         // line here was a glitch and is dropped silently.
         S_START: begin
            if (cnt_q == HALF_C) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // From the start-bit midpoint, each full bit period lands on the
         // next bit's midpoint.
         S_DATA: begin
            if (cnt_q == FULL_C) begin
               cnt_d   = '0;
               shift_d = {rx, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_STOP: begin
            if (cnt_q == FULL_C) begin
               cnt_d = '0;
               if (rx) begin
                  data_d  = shift_q;
                  dr_d    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // A low stop bit may be a line break; wait for the line to return
         // high so the held-low level is not taken as a new start bit.
         S_BREAK: begin
            if (rx) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign RxD_data    = data_q;
   assign data_ready  = dr_q;
   assign frame_error = fe_q;
   assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_receiver.sv
module tb_receiver;

   localparam int unsigned SD  = 3;
   localparam int unsigned BIT = SD + 1;

   logic       clk;
   logic       rst;
   logic       RxD;
   logic [7:0] RxD_data;
   logic       data_ready;
   logic       frame_error;
   logic       rx_busy;

   int unsigned checks = 0;
   int unsigned errors = 0;

   int unsigned cyc = 0;
   logic [7:0]  dr_data[$];
   int unsigned dr_cyc[$];
   int unsigned fe_cnt = 0;
   int unsigned busy_run = 0;
   int unsigned busy_max = 0;
   int unsigned fall_cyc = 0;
   int unsigned fall_first = 0;

   receiver #(.SIGNAL_DURATION(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .RxD        (RxD),
      .RxD_data   (RxD_data),
      .data_ready (data_ready),
      .frame_error(frame_error),
      .rx_busy    (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (data_ready) begin
            dr_data.push_back(RxD_data);
            dr_cyc.push_back(cyc);
         end
         if (frame_error) fe_cnt++;
         if (data_ready || frame_error) begin
            checks++;
            assert (!(data_ready && frame_error))
            else begin
               errors++;
               $error("FAIL pulse_overlap observed dr=%0b fe=%0b expected not both", data_ready, frame_error);
            end
         end
         if (rx_busy) busy_run++;
         else begin
            if (busy_run > busy_max) busy_max = busy_run;
            busy_run = 0;
         end
      end
   end

   task automatic wait_clks(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      RxD = b;
      wait_clks(BIT);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [7:0] v;
      v = d;
      fall_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      send_bit(stop);
   endtask

   initial begin
      rst = 1'b1;
      RxD = 1'b1;
      wait_clks(4);

      // reset state
      check("reset_data",  {24'h0, RxD_data}, 32'h00);
      check("reset_dr",    {31'h0, data_ready}, 32'h0);
      check("reset_fe",    {31'h0, frame_error}, 32'h0);
      check("reset_busy",  {31'h0, rx_busy}, 32'h0);
      rst = 1'b0;
      wait_clks(4);

      // single frame 0x5D
      send_frame(8'h5D, 1'b1);
      wait_clks(8);
      check("single_cnt",  dr_data.size(), 1);
      check("single_val",  {24'h0, dr_data[0]}, 32'h5D);
      check("single_out",  {24'h0, RxD_data}, 32'h5D);
      check("single_fe",   fe_cnt, 0);
      check("single_busy", {31'h0, rx_busy}, 32'h0);
      // start bit driven after edge c0; data_ready seen after edge c0+41
      check("single_lat_window",
            {31'h0, ((dr_cyc[0] - fall_cyc) >= 39) && ((dr_cyc[0] - fall_cyc) <= 41)}, 32'h1);
      dr_data.delete(); dr_cyc.delete();

      // back-to-back 0x5D, 0x65 with no idle gap
      send_frame(8'h5D, 1'b1);
      send_frame(8'h65, 1'b1);
      RxD = 1'b1;
      wait_clks(8);
      check("b2b_cnt",  dr_data.size(), 2);
      check("b2b_val0", {24'h0, dr_data[0]}, 32'h5D);
      check("b2b_val1", {24'h0, dr_data[1]}, 32'h65);
      check("b2b_gap",  dr_cyc[1] - dr_cyc[0], 40);
      check("b2b_fe",   fe_cnt, 0);
      dr_data.delete(); dr_cyc.delete();

      // one-clock glitch
      busy_max = 0;
      RxD = 1'b0;
      wait_clks(1);
      RxD = 1'b1;
      wait_clks(12);
      check("glitch_dr",   dr_data.size(), 0);
      check("glitch_fe",   fe_cnt, 0);
      check("glitch_busy", {31'h0, (busy_max >= 1) && (busy_max <= 2)}, 32'h1);
      check("glitch_data", {24'h0, RxD_data}, 32'h65);

      // framing error followed by a held-low line, then a good frame
      send_frame(8'h5D, 1'b1);
      send_frame(8'hA5, 1'b0);
      RxD = 1'b0;
      wait_clks(20);
      check("fe_cnt",      fe_cnt, 1);
      check("fe_data",     {24'h0, RxD_data}, 32'h5D);
      check("fe_hold_dr",  dr_data.size(), 1);
      check("fe_hold_busy", {31'h0, rx_busy}, 32'h1);
      RxD = 1'b1;
      wait_clks(8);
      check("fe_idle_busy", {31'h0, rx_busy}, 32'h0);
      send_frame(8'h3C, 1'b1);
      wait_clks(8);
      check("fe_after_cnt", dr_data.size(), 2);
      check("fe_after_val", {24'h0, RxD_data}, 32'h3C);
      check("fe_after_fe",  fe_cnt, 1);
      dr_data.delete(); dr_cyc.delete();

      // reset during data bit 4 of 0xFF
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_clks(2);
      rst = 1'b1;
      wait_clks(1);
      check("mid_rst_data", {24'h0, RxD_data}, 32'h00);
      check("mid_rst_dr",   {31'h0, data_ready}, 32'h0);
      check("mid_rst_fe",   {31'h0, frame_error}, 32'h0);
      check("mid_rst_busy", {31'h0, rx_busy}, 32'h0);
      rst = 1'b0;
      RxD = 1'b1;
      wait_clks(40);
      check("mid_rst_nopulse", dr_data.size(), 0);
      send_frame(8'h01, 1'b1);
      wait_clks(8);
      check("mid_rst_cnt", dr_data.size(), 1);
      check("mid_rst_val", {24'h0, RxD_data}, 32'h01);
      check("mid_rst_fe",  fe_cnt, 1);
      dr_data.delete(); dr_cyc.delete();

      // transmitter-style stream 0x00, 0xFF, 0x55
      fall_first = cyc;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      RxD = 1'b1;
      wait_clks(8);
      check("loop_cnt",  dr_data.size(), 3);
      check("loop_val0", {24'h0, dr_data[0]}, 32'h00);
      check("loop_val1", {24'h0, dr_data[1]}, 32'hFF);
      check("loop_val2", {24'h0, dr_data[2]}, 32'h55);
      check("loop_fe",   fe_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter SIGNAL_DURATION, default 433, clock cycles per bit minus one; minimum legal value 1.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 RxD  input  1  asynchronous serial line; idle high.
REQ-005 RxD_data  output  8  last correctly framed byte.
REQ-006 data_ready  output  1  one-cycle pulse when RxD_data is updated.
REQ-007 frame_error  output  1  one-cycle pulse on an invalid stop bit.
REQ-008 rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-010 RxD SHALL pass through a 2-flop synchronizer before use; the synchronizer resets to 1.
REQ-011 Define HALF = SIGNAL_DURATION/2 (integer division); the bit counter is wide enough for SIGNAL_DURATION.
REQ-012 States SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: on synchronized RxD = 0, go to START with the counter cleared.
REQ-014 START: increment the counter; when it reaches HALF, go to DATA if RxD = 0, otherwise go to IDLE as a glitch with no output pulse.
REQ-015 DATA: count 0..SIGNAL_DURATION; at SIGNAL_DURATION, shift the sampled bit into the shift register MSB (shift right) and clear the counter.
REQ-016 DATA: after the 8th sample, go to STOP.
REQ-017 STOP: at count SIGNAL_DURATION, sample RxD.
REQ-018 STOP with sample 1: load RxD_data from the shift register, pulse data_ready for exactly one cycle, and go to IDLE.
REQ-019 STOP with sample 0: pulse frame_error for exactly one cycle, leave RxD_data unchanged, and go to BREAK.
REQ-020 BREAK: stay until synchronized RxD = 1, then go to IDLE; no new frame starts while the line is held low.
REQ-021 Samples SHALL occur at the bit midpoints, i.e. HALF + k*(SIGNAL_DURATION+1) cycles after start-bit detection, k = 1..9.
REQ-022 data_ready SHALL assert HALF + 9*(SIGNAL_DURATION+1) + 3 cycles (±1) after the RxD falling edge at the pin.
REQ-023 A new start bit directly following a stop bit (no idle gap) SHALL be received correctly.
REQ-024 data_ready and frame_error SHALL never be high in the same cycle.
REQ-025 RxD_data SHALL hold its value between data_ready pulses.

Reset
REQ-026 While rst is high at a clock edge: state = IDLE, counter = 0, bit index = 0, shift register = 0, RxD_data = 0x00, data_ready = 0, frame_error = 0, rx_busy = 0, synchronizer = 1.
REQ-027 rst asserted mid-frame SHALL abort the frame with no output pulse; reception restarts on the next falling edge after rst deasserts.

Verification (bench uses SIGNAL_DURATION = 3, i.e. 4 clocks per bit)
REQ-028 Single frame 0x5D (line 0,1,0,1,1,1,0,1,0,1) -> exactly one data_ready pulse, RxD_data = 0x5D, frame_error stays 0, rx_busy falls back to 0.
REQ-029 Back-to-back frames 0x5D then 0x65 with no idle gap -> two data_ready pulses 40 clocks apart, values 0x5D then 0x65.
REQ-030 RxD low for 1 clock, then high -> no pulse; rx_busy high for at most HALF+1 cycles.
REQ-031 Frame 0xA5 with stop bit 0 after a good 0x5D, line held low 20 clocks, then high, then frame 0x3C -> one frame_error pulse, RxD_data stays 0x5D, no pulse during the low hold, then data_ready with 0x3C.
REQ-032 rst pulsed during data bit 4 of 0xFF -> all outputs at reset values on the next edge, no pulse; a following frame 0x01 is received as 0x01.
REQ-033 Loopback from the transmitter block at the same SIGNAL_DURATION sending 0x00, 0xFF, 0x55 -> received in order with no frame_error.
